// File: rtl/effect_pkg.sv
`default_nettype none
// ============================================================================
// effect_pkg : shared constants and effect codes for the effect_mixer stage
// Revision   : 1.0
// ============================================================================
package effect_pkg;

   localparam int CH_W  = 10;
   localparam int PIX_W = 3 * CH_W;

   // Pixel layout {R,G,B}
   localparam int R_HI = 3 * CH_W - 1;
   localparam int R_LO = 2 * CH_W;
   localparam int G_HI = 2 * CH_W - 1;
   localparam int G_LO = CH_W;
   localparam int B_HI = CH_W - 1;
   localparam int B_LO = 0;

   localparam int MIX_MAX = 16;

   typedef logic [2:0] fx_code_t;

   localparam fx_code_t FX_INVERT = 3'd0;
   localparam fx_code_t FX_GRAY   = 3'd1;
   localparam fx_code_t FX_RED    = 3'd2;
   localparam fx_code_t FX_ROTATE = 3'd3;
   localparam fx_code_t FX_POSTER = 3'd4;
   localparam fx_code_t FX_PIXEL  = 3'd5;
   localparam fx_code_t FX_SCAN   = 3'd6;
   localparam fx_code_t FX_THRESH = 3'd7;

   localparam logic [CH_W-1:0] POSTER_MASK = 10'h380;

endpackage
`default_nettype wire

// File: rtl/channel_blend.sv
`default_nettype none
// ============================================================================
// channel_blend : registered crossfade of one colour channel, (E*m + O*(full-m)) >> shift
// Revision      : 1.0
// ============================================================================
module channel_blend
   import effect_pkg::*;
#(
   parameter int RAMP_SHIFT = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [CH_W-1:0]     e,
   input  logic [CH_W-1:0]     o,
   input  logic [RAMP_SHIFT:0] m,
   output logic [CH_W-1:0]     blend
);

   localparam int                  PROD_W = CH_W + RAMP_SHIFT;
   localparam logic [RAMP_SHIFT:0] M_FULL = {1'b1, {RAMP_SHIFT{1'b0}}};

   logic [PROD_W-1:0] prod_e;
   logic [PROD_W-1:0] prod_o;
   logic [PROD_W-1:0] sum;
   logic [CH_W-1:0]   blend_d;
   logic [CH_W-1:0]   blend_q;

   // The weights sum to M_FULL, so the total never exceeds (2^CH_W-1)*M_FULL
   always_comb begin
      prod_e  = PROD_W'(e) * PROD_W'(m);
      prod_o  = PROD_W'(o) * PROD_W'(M_FULL - m);
      sum     = prod_e + prod_o;
      blend_d = CH_W'(sum >> RAMP_SHIFT);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         blend_q <= '0;
      end else begin
         blend_q <= blend_d;
      end
   end

   assign blend = blend_q;

endmodule
`default_nettype wire

// File: rtl/effect_mixer.sv
`default_nettype none
// ============================================================================
// effect_mixer : colour effect with 16-frame crossfade and icon overlay, 3-cycle pipeline
// Revision     : 1.0
// ============================================================================
module effect_mixer
   import effect_pkg::*;
#(
   parameter int H_LAST     = 639,
   parameter int V_LAST     = 479,
   parameter int RAMP_SHIFT = $clog2(MIX_MAX)
) (
   input  logic             clk,
   input  logic             reset,
   input  fx_code_t         effect,
   input  logic             effect_en,
   input  logic [9:0]       x,
   input  logic [9:0]       y,
   input  logic [PIX_W-1:0] cam_pixel,
   input  logic [PIX_W-1:0] icon_pixel,
   output logic [PIX_W-1:0] out_pixel,
   output logic [9:0]       out_x,
   output logic [9:0]       out_y
);

   localparam logic [RAMP_SHIFT:0] M_FULL   = {1'b1, {RAMP_SHIFT{1'b0}}};
   localparam logic [9:0]          X_STROBE = 10'(H_LAST);
   localparam logic [9:0]          Y_STROBE = 10'(V_LAST);

   logic [RAMP_SHIFT:0] m_d, m_q, m_s1_d, m_s1_q;
   fx_code_t            effect_sel_d, effect_sel_q;
   logic [PIX_W-1:0]    hold_d, hold_q;
   logic [PIX_W-1:0]    e_s1_d, e_s1_q, o_s1_d, o_s1_q;
   logic [PIX_W-1:0]    icon_s2_d, icon_s2_q;
   logic [PIX_W-1:0]    out_pixel_d, out_pixel_q;
   logic [9:0]          x_s1_d, x_s1_q, y_s1_d, y_s1_q;
   logic [9:0]          x_s2_d, x_s2_q, y_s2_d, y_s2_q;
   logic [9:0]          out_x_d, out_x_q, out_y_d, out_y_q;
   logic [PIX_W-1:0]    blend_s2;

   logic                strobe;
   logic [CH_W-1:0]     cam_r, cam_g, cam_b, gray;
   logic [CH_W+1:0]     gray_sum;

   // Stage 0: effect value from the latched effect code
   always_comb begin
      cam_r    = cam_pixel[R_HI:R_LO];
      cam_g    = cam_pixel[G_HI:G_LO];
      cam_b    = cam_pixel[B_HI:B_LO];
      gray_sum = {2'b00, cam_r} + {1'b0, cam_g, 1'b0} + {2'b00, cam_b};
      gray     = CH_W'(gray_sum >> 2);

      e_s1_d = cam_pixel;
      case (effect_sel_q)
         FX_INVERT: e_s1_d = ~cam_pixel;
         FX_GRAY:   e_s1_d = {gray, gray, gray};
         FX_RED:    e_s1_d = {cam_r, {(2 * CH_W){1'b0}}};
         FX_ROTATE: e_s1_d = {cam_g, cam_b, cam_r};
         FX_POSTER: e_s1_d = cam_pixel & {3{POSTER_MASK}};
         FX_PIXEL:  e_s1_d = (x[2:0] == 3'd0) ? cam_pixel : hold_q;
         FX_SCAN:   if (y[1]) e_s1_d = {cam_r >> 1, cam_g >> 1, cam_b >> 1};
         FX_THRESH: e_s1_d = gray[CH_W-1] ? '1 : '0;
         default:   e_s1_d = cam_pixel;
      endcase

      hold_d = (x[2:0] == 3'd0) ? cam_pixel : hold_q;
      o_s1_d = cam_pixel;
      x_s1_d = x;
      y_s1_d = y;
      m_s1_d = m_q;
   end

   // Mix level steps once per frame; the effect code only follows the selector while faded out
   always_comb begin
      strobe = (x == X_STROBE) && (y == Y_STROBE);
      m_d    = m_q;
      if (strobe) begin
         if (effect_en && (m_q < M_FULL)) begin
            m_d = m_q + 1'b1;
         end else if (!effect_en && (m_q != '0)) begin
            m_d = m_q - 1'b1;
         end
      end
      effect_sel_d = (m_q == '0) ? effect : effect_sel_q;
   end

   // Stage 1 -> 2 blend, one instance per colour channel
   for (genvar i = 0; i < 3; i++) begin : g_chan
      channel_blend #(
         .RAMP_SHIFT(RAMP_SHIFT)
      ) u_blend (
         .clk   (clk),
         .reset (reset),
         .e     (e_s1_q[i*CH_W +: CH_W]),
         .o     (o_s1_q[i*CH_W +: CH_W]),
         .m     (m_s1_q),
         .blend (blend_s2[i*CH_W +: CH_W])
      );
   end

   always_comb begin
      icon_s2_d   = icon_pixel;
      x_s2_d      = x_s1_q;
      y_s2_d      = y_s1_q;
      out_pixel_d = (icon_s2_q != '0) ? icon_s2_q : blend_s2;
      out_x_d     = x_s2_q;
      out_y_d     = y_s2_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         m_q          <= '0;
         effect_sel_q <= '0;
         hold_q       <= '0;
         e_s1_q       <= '0;
         o_s1_q       <= '0;
         m_s1_q       <= '0;
         x_s1_q       <= '0;
         y_s1_q       <= '0;
         icon_s2_q    <= '0;
         x_s2_q       <= '0;
         y_s2_q       <= '0;
         out_pixel_q  <= '0;
         out_x_q      <= '0;
         out_y_q      <= '0;
      end else begin
         m_q          <= m_d;
         effect_sel_q <= effect_sel_d;
         hold_q       <= hold_d;
         e_s1_q       <= e_s1_d;
         o_s1_q       <= o_s1_d;
         m_s1_q       <= m_s1_d;
         x_s1_q       <= x_s1_d;
         y_s1_q       <= y_s1_d;
         icon_s2_q    <= icon_s2_d;
         x_s2_q       <= x_s2_d;
         y_s2_q       <= y_s2_d;
         out_pixel_q  <= out_pixel_d;
         out_x_q      <= out_x_d;
         out_y_q      <= out_y_d;
      end
   end

   assign out_pixel = out_pixel_q;
   assign out_x     = out_x_q;
   assign out_y     = out_y_q;

endmodule
`default_nettype wire

// File: doc/effect_mixer.md
# effect_mixer

Video effect stage directly downstream of the icon selector. It consumes the selector's `effect`/`effect_en` outputs, its 30-bit icon overlay pixel, the camera pixel stream and the VGA scan coordinates. It applies the selected colour effect to the camera pixel and crossfades the effect in and out over 16 frames. Icon pixels are laid over the result, and the block drives the final 30-bit pixel to the VGA output register.

## Interface
- `H_LAST`, default 639: last active x; frame strobe column.
- `V_LAST`, default 479: last active y; frame strobe row.
- `RAMP_SHIFT`, default 4: crossfade resolution; the mix level runs 0..2^RAMP_SHIFT.

Ports:
- `clk`  in  1: pixel clock; the block has one clock.
- `reset`  in  1: asynchronous, active-high; clears all state immediately.
- `effect`  in  3: effect code from the icon selector.
- `effect_en`  in  1: effect request from the icon selector.
- `x`, `y`  in  10 each: scan coordinates for `cam_pixel`, same cycle.
- `cam_pixel`  in  30: camera pixel {R[29:20],G[19:10],B[9:0]} for the current x,y.
- `icon_pixel`  in  30: icon selector output; it arrives one cycle after the x,y it belongs to.
- `out_pixel`  out  30: final pixel.
- `out_x`, `out_y`  out  10 each: coordinates of `out_pixel`.

## Operation
- **Effect value E**, per channel c (10-bit), computed from the stage-0 inputs:
  - 0 invert: 1023−c.
  - 1 grayscale: all channels = (R+2G+B)>>2; 12-bit sum, result ≤1023.
  - 2 red-only: G=B=0.
  - 3 rotate: {G,B,R}.
  - 4 posterize: c & 10'h380.
  - 5 pixelate: `hold` loads `cam_pixel` when x[2:0]==0. E = `cam_pixel` at those columns, otherwise `hold`.
  - 6 scanline: rows with y[1]==1 give c>>1; other rows pass unchanged.
  - 7 threshold: gray ≥512 gives 30'h3FFFFFFF, otherwise 0.
- **Mix level m**, 0..16:
  - Frame strobe = (x==H_LAST && y==V_LAST) at the input.
  - On a strobe, m increments if `effect_en`=1 and m<16, and decrements if `effect_en`=0 and m>0.
  - The `effect_en` value sampled on the strobe cycle is the one used.
  - m saturates at both ends; there is no wrap.
- **Effect latch `effect_sel`:**
  - Loads `effect` on every cycle where m==0.
  - Frozen while m>0, so the fade-out keeps the last effect even though the selector has already returned `effect` to 0.
  - Effect computation uses `effect_sel`.
- **Blend**, per channel: out = (E·m + O·(16−m))>>4. O is the unmodified camera channel. Products are 14 bits wide.
  - m=16 gives exactly E.
  - m=0 gives exactly O.
- **Overlay:** if `icon_pixel` ≠0, `out_pixel` = `icon_pixel`; otherwise the blend result.

## Timing
- **Pipeline.** Inputs x,y,`cam_pixel` arrive at cycle t.
  - Edge t+1: E and O are registered, with coordinates.
  - Edge t+2: the blend is registered. `icon_pixel` present at cycle t+1 is registered alongside it.
  - Edge t+3: the overlay mux is registered onto the outputs.
  - Latency is fixed at 3 cycles, with no stalls and no handshake.
- **m update:** a change on the strobe edge affects pixels entering from the next cycle, i.e. the next frame.
- **Reset:** `out_pixel`, `out_x`, `out_y`, all pipeline registers, `hold`, m and `effect_sel` go to 0 asynchronously. The first valid output is 3 cycles after reset deasserts.
- **Reset mid-fade:** m returns to 0, and the next frame shows the unmodified camera picture.
- **Effect change while m>0:** the change is ignored until m reaches 0.
- **`effect_en` re-raised mid-fade-out:** m ramps back up from its current value with the same `effect_sel`.

## Structure
- Package `effect_pkg` holds:
  - The effect code localparams (`FX_INVERT`…`FX_THRESH`).
  - The channel width (10).
  - The pixel field slice constants.
  - `MIX_MAX`=16.
- Sub-module `channel_blend` is instantiated 3× (R,G,B). It takes a 10-bit E, a 10-bit O and a 5-bit m, and produces the registered 10-bit blend.

## Test plan
- **Reset:** assert `reset` mid-frame with nonzero pipeline contents → all outputs are 0 in the same cycle. After release, a pixel entered at t appears at t+3 with matching `out_x`/`out_y`.
- **Bypass:** m=0, `cam_pixel`={R=600,G=300,B=100}, `icon_pixel`=0 → `out_pixel` equals `cam_pixel` exactly.
- **Full invert:** `effect`=0, `effect_en`=1 for 16 strobes → m=16. `cam_pixel` {R=600,G=300,B=100} → {R=423,G=723,B=923}.
- **Half blend:** `effect`=1 with m=8, `cam_pixel` {R=1000,G=200,B=0} → gray=350, output {675,275,175}.
- **Fade-out latch:** hold `effect`=4 at m=16, then drop `effect_en` and set `effect`=0 on the same cycle → posterize stays active while m steps 15…0 over 16 frames. After m reaches 0, `effect_sel` reads 0.
- **Overlay and pixelate:** `effect`=5, m=16, `icon_pixel`=30'h3FF00000 at x=150..181 → red icon pixels override the output. Outside the icon, x=8..15 all output the camera value sampled at x=8.
